// File: rtl/mem_access_unit.sv
// Single-request memory access sequencer: issues one load or store to an
// external memory, writes load data back to the register bank, aborts on timeout.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       isLoad,
   input  logic [7:0] addr,
   input  logic [7:0] storeData,
   output logic       memReq,
   output logic       memWe,
   output logic [7:0] memAddr,
   output logic [7:0] memWdata,
   input  logic [7:0] memRdata,
   input  logic       memAck,
   output logic [7:0] memWrite,
   output logic       RegMemWrite,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WB   = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

   state_t      state_r;
   state_t      state_s;
   logic [3:0]  cnt_r;
   logic        isload_r;
   logic [7:0]  addr_r;
   logic [7:0]  wdata_r;
   logic        we_r;
   logic [7:0]  rdata_r;
   logic        req_r;
   logic        wb_r;
   logic        busy_r;
   logic        done_r;
   logic        error_r;

   logic        req_s;
   logic        wb_s;
   logic        busy_s;
   logic        done_s;
   logic        error_s;
   logic        accept_s;

   assign accept_s = (state_r == ST_IDLE) && start;

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; an ack in the last allowed REQ cycle beats the timeout.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (memAck) begin
               if (isload_r) begin
                  state_s = ST_WB;
               end else begin
                  state_s = ST_DONE;
               end
            end else if (cnt_r == CNT_LAST) begin
               state_s = ST_ERR;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WB:   state_s = ST_DONE;
         ST_DONE: state_s = ST_IDLE;
         ST_ERR:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state so the strobes leave a register aligned with the state.
   always_comb begin
      req_s   = 1'b0;
      wb_s    = 1'b0;
      done_s  = 1'b0;
      error_s = 1'b0;
      busy_s  = (state_s != ST_IDLE);
      case (state_s)
         ST_IDLE: req_s = 1'b0;
         ST_REQ:  req_s = 1'b1;
         ST_WB:   wb_s  = 1'b1;
         ST_DONE: done_s = 1'b1;
         ST_ERR: begin
            done_s  = 1'b1;
            error_s = 1'b1;
         end
         default: req_s = 1'b0;
      endcase
   end

   // Registered control outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         req_r   <= 1'b0;
         wb_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
      end else begin
         req_r   <= req_s;
         wb_r    <= wb_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         error_r <= error_s;
      end
   end

   // Operand latches; only a start accepted in IDLE may change them.
   always_ff @(posedge clock) begin
      if (!reset) begin
         addr_r   <= 8'h00;
         wdata_r  <= 8'h00;
         isload_r <= 1'b0;
         we_r     <= 1'b0;
      end else if (accept_s) begin
         addr_r   <= addr;
         wdata_r  <= storeData;
         isload_r <= isLoad;
         we_r     <= ~isLoad;
      end
   end

   // Timeout counter: cleared on accept, counts unacknowledged REQ cycles.
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_r <= 4'd0;
      end else if (accept_s) begin
         cnt_r <= 4'd0;
      end else if ((state_r == ST_REQ) && !memAck) begin
         cnt_r <= cnt_r + 4'd1;
      end
   end

   // Load result register; untouched by stores and timeouts.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rdata_r <= 8'h00;
      end else if ((state_r == ST_REQ) && memAck && isload_r) begin
         rdata_r <= memRdata;
      end
   end

   assign memReq      = req_r;
   assign memWe       = we_r;
   assign memAddr     = addr_r;
   assign memWdata    = wdata_r;
   assign memWrite    = rdata_r;
   assign RegMemWrite = wb_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign error       = error_r;

endmodule
